tx_fifo_arbiter: RTL and testbench

Round-robin arbiter and byte serializer that shares the single TX async-FIFO write port (REF_CLK domain) among several requesters: the system controller's register-read responses, 16-bit ALU results and status/echo sources. Each requester hands over one 1- or 2-byte word with a valid/ready handshake. The block drives the FIFO write data and increment, LSB byte first, and stalls on FIFO full.

---
 rtl/tx_fifo_arbiter.sv | 148 ++++++++++++++
 tb/tb_tx_fifo_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: shares the single TX async-FIFO write port among N_REQ
// requesters. One word (1 or 2 bytes) is accepted at a time, chosen by
// round-robin, then serialized LSB byte first, stalling while the FIFO is full.
// Optional feature macro: TX_ARB_STRICT_PRIO_EN gives requester 0 absolute
// priority, with round-robin among the remaining requesters.
module tx_fifo_arbiter #(
    parameter int WIDTH  = 8,
    parameter int N_REQ  = 3,
    parameter int CNT_WD = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           REQ_VLD,
    input  logic [N_REQ*2*WIDTH-1:0]   REQ_DATA,
    input  logic [N_REQ-1:0]           REQ_TWO,
    output logic [N_REQ-1:0]           REQ_RDY,
    input  logic                       FIFO_FULL,
    output logic [WIDTH-1:0]           TX_P_Data,
    output logic                       TX_D_VLD,
    output logic                       BUSY,
    output logic [$clog2(N_REQ)-1:0]   GNT_ID,
    output logic [CNT_WD-1:0]          BYTE_CNT
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] hold;
    logic               two;
    logic [ID_W-1:0]    last_id;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [N_REQ-1:0]   grant;
    logic [2*WIDTH-1:0] sel_word;
    logic               accept;

    // Pick the first valid requester after the previous winner, wrapping around.
    always_comb begin
        cand      = '0;
        grant_id  = '0;
        grant_any = 1'b0;
`ifdef TX_ARB_STRICT_PRIO_EN
        if (REQ_VLD[0]) begin
            grant_any = 1'b1;
        end else begin
            for (int k = 1; k < N_REQ; k++) begin
                cand = ID_W'((int'(last_id) - 1 + k) % (N_REQ - 1) + 1);
                if (!grant_any && REQ_VLD[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_id) + k) % N_REQ);
            if (!grant_any && REQ_VLD[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
`endif
        grant = grant_any ? (N_REQ'(1) << grant_id) : '0;
    end

    // Select the granted requester's word for capture into the hold register.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_word = REQ_DATA[i*2*WIDTH +: 2*WIDTH];
            end
        end
    end

    assign accept = (state == IDLE) && grant_any;
    assign BUSY   = (state != IDLE);

    // Next state: accept in IDLE, step through the bytes whenever the FIFO has room.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = SEND_LO;
            SEND_LO: if (!FIFO_FULL) state_nxt = two ? SEND_HI : IDLE;
            SEND_HI: if (!FIFO_FULL) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on registered state and FIFO_FULL, except the IDLE grant.
    always_comb begin
        REQ_RDY   = '0;
        TX_P_Data = '0;
        TX_D_VLD  = 1'b0;
        case (state)
            IDLE: begin
                if (RST) REQ_RDY = grant;
            end
            SEND_LO: begin
                TX_P_Data = hold[WIDTH-1:0];
                TX_D_VLD  = !FIFO_FULL;
            end
            SEND_HI: begin
                TX_P_Data = hold[2*WIDTH-1:WIDTH];
                TX_D_VLD  = !FIFO_FULL;
            end
            default: begin
                REQ_RDY = '0;
            end
        endcase
    end

    // State register; reset drops any half-sent word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Capture the accepted word and remember the winner for the next rotation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold    <= '0;
            two     <= 1'b0;
            GNT_ID  <= '0;
            last_id <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            hold   <= sel_word;
            two    <= REQ_TWO[grant_id];
            GNT_ID <= grant_id;
`ifdef TX_ARB_STRICT_PRIO_EN
            if (grant_id != '0) last_id <= grant_id;
`else
            last_id <= grant_id;
`endif
        end
    end

    // Count every byte actually pushed into the FIFO; wraps naturally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)          BYTE_CNT <= '0;
        else if (TX_D_VLD) BYTE_CNT <= BYTE_CNT + CNT_WD'(1);
    end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb_tx_fifo_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the arbiter/serializer.
`timescale 1ns/1ps
module tb_tx_fifo_arbiter;

    localparam int WIDTH  = 8;
    localparam int N_REQ  = 3;
    localparam int CNT_WD = 10;          // narrowed so the counter wrap is reachable quickly
    localparam int ID_W   = $clog2(N_REQ);
    localparam int WRAP   = 1 << CNT_WD;

    logic                     CLK       = 1'b0;
    logic                     RST       = 1'b0;
    logic [N_REQ-1:0]         REQ_VLD   = '0;
    logic [N_REQ*2*WIDTH-1:0] REQ_DATA  = '0;
    logic [N_REQ-1:0]         REQ_TWO   = '0;
    logic                     FIFO_FULL = 1'b0;
    logic [N_REQ-1:0]         REQ_RDY;
    logic [WIDTH-1:0]         TX_P_Data;
    logic                     TX_D_VLD;
    logic                     BUSY;
    logic [ID_W-1:0]          GNT_ID;
    logic [CNT_WD-1:0]        BYTE_CNT;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model_q [$];
    int               model_last  = N_REQ - 1;
    int               model_owner = 0;
    int               model_cnt   = 0;
    logic [WIDTH-1:0] dut_log [$];

    tx_fifo_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .CNT_WD(CNT_WD)) dut (
        .CLK(CLK), .RST(RST), .REQ_VLD(REQ_VLD), .REQ_DATA(REQ_DATA),
        .REQ_TWO(REQ_TWO), .REQ_RDY(REQ_RDY), .FIFO_FULL(FIFO_FULL),
        .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY),
        .GNT_ID(GNT_ID), .BYTE_CNT(BYTE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] vld, input logic [N_REQ*2*WIDTH-1:0] data,
                                 input logic [N_REQ-1:0] two, input logic full);
        REQ_VLD   = vld;
        REQ_DATA  = data;
        REQ_TWO   = two;
        FIFO_FULL = full;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(1);
    endtask

    // Winner = valid requester closest (cyclically) after the previous winner.
    function automatic int pick(input logic [N_REQ-1:0] vld, input int last);
        int best      = -1;
        int best_dist = N_REQ;
        int d;
`ifdef TX_ARB_STRICT_PRIO_EN
        if (vld[0]) return 0;
        for (int i = 1; i < N_REQ; i++) begin
            d = (i - last - 1 + 2*(N_REQ-1)) % (N_REQ-1);
            if (vld[i] && d < best_dist) begin best = i; best_dist = d; end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            d = (i - last - 1 + 2*N_REQ) % N_REQ;
            if (vld[i] && d < best_dist) begin best = i; best_dist = d; end
        end
`endif
        return best;
    endfunction

    // Model: bytes of the held word still to be written; checked on every falling edge.
    always @(negedge CLK) begin
        int               p;
        logic [N_REQ-1:0] exp_rdy;
        logic [2*WIDTH-1:0] word;
        if (!RST) begin
            model_q.delete();
            model_last  = N_REQ - 1;
            model_owner = 0;
            model_cnt   = 0;
            checkOutput("rst_rdy",  REQ_RDY,   0);
            checkOutput("rst_vld",  TX_D_VLD,  0);
            checkOutput("rst_data", TX_P_Data, 0);
            checkOutput("rst_busy", BUSY,      0);
            checkOutput("rst_gnt",  GNT_ID,    0);
            checkOutput("rst_cnt",  BYTE_CNT,  0);
        end else begin
            p       = (model_q.size() == 0) ? pick(REQ_VLD, model_last) : -1;
            exp_rdy = (p >= 0) ? (N_REQ'(1) << p) : '0;
            checkOutput("rdy",  REQ_RDY,   exp_rdy);
            checkOutput("busy", BUSY,      model_q.size() != 0);
            checkOutput("vld",  TX_D_VLD,  model_q.size() != 0 && !FIFO_FULL);
            checkOutput("data", TX_P_Data, (model_q.size() != 0) ? model_q[0] : 8'h00);
            checkOutput("gnt",  GNT_ID,    model_owner);
            checkOutput("cnt",  BYTE_CNT,  model_cnt);
            if (TX_D_VLD) dut_log.push_back(TX_P_Data);
            if (model_q.size() != 0) begin
                if (!FIFO_FULL) begin
                    void'(model_q.pop_front());
                    model_cnt = (model_cnt + 1) % WRAP;
                end
            end else if (p >= 0) begin
                word = REQ_DATA[p*2*WIDTH +: 2*WIDTH];
                model_q.push_back(word[WIDTH-1:0]);
                if (REQ_TWO[p]) model_q.push_back(word[2*WIDTH-1:WIDTH]);
                model_owner = p;
`ifdef TX_ARB_STRICT_PRIO_EN
                if (p != 0) model_last = p;
`else
                model_last = p;
`endif
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [7:0] rr_exp [6];
        logic [N_REQ-1:0] acc;
`ifdef TX_ARB_STRICT_PRIO_EN
        rr_exp = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
        rr_exp = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
`endif
        tick(3);
        RST = 1'b1;
        tick(1);

        $display("[TB] two-byte word A55A from requester 0");
        applyStimulus(3'b001, {16'h0000, 16'h0000, 16'hA55A}, 3'b001, 1'b0);
        #1 checkOutput("t1_rdy", REQ_RDY, 3'b001);
        tick(1);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        #1;
        checkOutput("t1_lo_vld",  TX_D_VLD,  1);
        checkOutput("t1_lo_data", TX_P_Data, 8'h5A);
        checkOutput("t1_lo_busy", BUSY,      1);
        checkOutput("t1_lo_rdy",  REQ_RDY,   0);
        tick(1);
        checkOutput("t1_hi_vld",  TX_D_VLD,  1);
        checkOutput("t1_hi_data", TX_P_Data, 8'hA5);
        checkOutput("t1_hi_busy", BUSY,      1);
        tick(1);
        checkOutput("t1_idle_busy", BUSY,     0);
        checkOutput("t1_cnt",       BYTE_CNT, 2);

        $display("[TB] three continuous single-byte requesters");
        doReset();
        dut_log.delete();
        applyStimulus(3'b111, {16'h0033, 16'h0022, 16'h0011}, 3'b000, 1'b0);
        tick(12);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        tick(4);
        checkOutput("t2_len", dut_log.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("t2_byte%0d", i), (i < dut_log.size()) ? dut_log[i] : 8'hxx, rr_exp[i]);

        $display("[TB] FIFO full during the high byte of BEEF");
        doReset();
        dut_log.delete();
        applyStimulus(3'b010, {16'h0000, 16'hBEEF, 16'h0000}, 3'b010, 1'b0);
        #1 checkOutput("t3_rdy", REQ_RDY, 3'b010);
        tick(1);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        #1;
        checkOutput("t3_lo_data", TX_P_Data, 8'hEF);
        checkOutput("t3_gnt",     GNT_ID,    1);
        tick(1);
        FIFO_FULL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("t3_full_vld%0d", i),  TX_D_VLD,  0);
            checkOutput($sformatf("t3_full_data%0d", i), TX_P_Data, 8'hBE);
            tick(1);
        end
        FIFO_FULL = 1'b0;
        #1;
        checkOutput("t3_retry_vld",  TX_D_VLD,  1);
        checkOutput("t3_retry_data", TX_P_Data, 8'hBE);
        tick(1);
        checkOutput("t3_idle_busy", BUSY, 0);
        checkOutput("t3_len",   dut_log.size(), 2);
        checkOutput("t3_byte0", (dut_log.size() > 0) ? dut_log[0] : 8'hxx, 8'hEF);
        checkOutput("t3_byte1", (dut_log.size() > 1) ? dut_log[1] : 8'hxx, 8'hBE);

        $display("[TB] single-byte word FF3C from requester 2");
        dut_log.delete();
        applyStimulus(3'b100, {16'hFF3C, 16'h0000, 16'h0000}, 3'b000, 1'b0);
        #1 checkOutput("t4_rdy", REQ_RDY, 3'b100);
        tick(1);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        #1 checkOutput("t4_data", TX_P_Data, 8'h3C);
        tick(1);
        checkOutput("t4_idle_busy", BUSY, 0);
        checkOutput("t4_len",   dut_log.size(), 1);
        checkOutput("t4_byte0", (dut_log.size() > 0) ? dut_log[0] : 8'hxx, 8'h3C);

        $display("[TB] reset in the middle of word 1234");
        applyStimulus(3'b001, {16'h0000, 16'h0000, 16'h1234}, 3'b001, 1'b0);
        tick(1);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        #1 checkOutput("t5_lo_data", TX_P_Data, 8'h34);
        RST = 1'b0;
        #1;
        checkOutput("t5_rst_vld",  TX_D_VLD,  0);
        checkOutput("t5_rst_data", TX_P_Data, 0);
        checkOutput("t5_rst_busy", BUSY,      0);
        checkOutput("t5_rst_cnt",  BYTE_CNT,  0);
        checkOutput("t5_rst_gnt",  GNT_ID,    0);
        dut_log.delete();
        tick(2);
        RST = 1'b1;
        tick(2);
        checkOutput("t5_no_resume", dut_log.size(), 0);
        checkOutput("t5_cnt",       BYTE_CNT, 0);
        applyStimulus(3'b111, {16'h0033, 16'h0022, 16'h00AB}, 3'b000, 1'b0);
        #1 checkOutput("t5_rdy", REQ_RDY, 3'b001);
        tick(1);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        tick(3);
        checkOutput("t5_len",   dut_log.size(), 1);
        checkOutput("t5_byte0", (dut_log.size() > 0) ? dut_log[0] : 8'hxx, 8'hAB);

        $display("[TB] byte counter wrap");
        doReset();
        applyStimulus(3'b001, {16'h0000, 16'h0000, 16'h00C3}, 3'b000, 1'b0);
        tick(2*WRAP - 1);
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        checkOutput("t6_cnt_max", BYTE_CNT, WRAP - 1);
        tick(1);
        checkOutput("t6_cnt_wrap", BYTE_CNT, 0);
        checkOutput("t6_busy",     BUSY,     0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            acc = REQ_VLD & REQ_RDY;
            @(posedge CLK);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (REQ_VLD[i] && !acc[i]) begin
                    if ($urandom_range(7) == 0) REQ_VLD[i] = 1'b0;
                end else begin
                    REQ_VLD[i] = 1'($urandom_range(1));
                    REQ_DATA[i*2*WIDTH +: 2*WIDTH] = 16'($urandom);
                    REQ_TWO[i] = 1'($urandom_range(1));
                end
            end
            FIFO_FULL = ($urandom_range(3) == 0);
        end
        applyStimulus(3'b000, '0, 3'b000, 1'b0);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
